// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, field formats, FSM states.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package instr_encoder_pkg;

    // Major opcodes, identical to the values the decode stage matches on
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Field-bundle format selector
    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_I      = 3'd1,
        FMT_LOAD   = 3'd2,
        FMT_STORE  = 3'd3,
        FMT_BRANCH = 3'd4,
        FMT_JAL    = 3'd5,
        FMT_JALR   = 3'd6,
        FMT_ILL    = 3'd7
    } fmt_e;

    // Program-level sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when imm[31:msb] are all equal, i.e. the value fits a (msb+1)-bit signed field
    function automatic logic sext_ok(input logic [31:0] imm, input int msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field-to-word packer for the RV32I formats; also flags unwritable bundles.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
// Build option: ENC_RANGE_CHECK_EN enables immediate range checking in o_range_ok.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_range_ok
);

    logic        w_shift;
    logic [11:0] w_imm_i;

    // funct3 001/101 on OP-IMM are shifts: shamt in [4:0], funct7 bit 5 selects arithmetic
    assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_imm_i = w_shift ? {1'b0, i_funct7_5, 5'b0, i_imm[4:0]} : i_imm[11:0];

    // Place each field in its slot; fields a format does not carry are forced to zero
    always_comb begin
        o_word = 32'h0;
        case (fmt_e'(i_fmt))
            FMT_R:      o_word = {1'b0, i_funct7_5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            FMT_I:      o_word = {w_imm_i, i_rs1, i_funct3, i_rd, OP_IMM};
            FMT_LOAD:   o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            FMT_STORE:  o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
            FMT_BRANCH: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                  i_imm[4:1], i_imm[11], OP_BRANCH};
            FMT_JAL:    o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            FMT_JALR:   o_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
            default:    o_word = 32'h0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Reject illegal formats and immediates that would be truncated or misaligned
    always_comb begin
        o_range_ok = 1'b1;
        case (fmt_e'(i_fmt))
            FMT_I:                        o_range_ok = w_shift ? (i_imm[31:5] == 27'd0)
                                                               : sext_ok(i_imm, 11);
            FMT_LOAD, FMT_STORE, FMT_JALR: o_range_ok = sext_ok(i_imm, 11);
            FMT_BRANCH:                   o_range_ok = sext_ok(i_imm, 12) && !i_imm[0];
            FMT_JAL:                      o_range_ok = sext_ok(i_imm, 20) && !i_imm[0];
            FMT_ILL:                      o_range_ok = 1'b0;
            default:                      o_range_ok = 1'b1;
        endcase
    end
`else
    logic w_unused_imm;

    // Without range checking the immediate is silently truncated; only format 7 is refused
    always_comb begin
        o_range_ok = (fmt_e'(i_fmt) != FMT_ILL);
    end

    // Upper immediate bits have no destination field when nothing is range checked
    assign w_unused_imm = ^i_imm[31:21];
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into words and writes them sequentially into IMEM.
// Latency: bundle accepted on edge t drives OUT_* from t+1; sustains one word per cycle.
// Backpressure: IN_READY low while a word is held with OUT_READY low; OUT_* hold stable meanwhile.
// Build option: define ENC_RANGE_CHECK_EN to reject immediates that do not fit their field.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_last,
    input  logic [2:0]        i_in_fmt,
    input  logic [2:0]        i_in_funct3,
    input  logic              i_in_funct7_5,
    input  logic [4:0]        i_in_rd,
    input  logic [4:0]        i_in_rs1,
    input  logic [4:0]        i_in_rs2,
    input  logic [31:0]       i_in_imm,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [31:0]       o_out_data,
    output logic              o_err,
    output logic              o_done,
    output logic [ADDR_W-2:0] o_instr_cnt
);

    // Low two bits dropped so every generated address stays word aligned
    localparam logic [ADDR_W-1:0] L_BASE = BASE_ADDR & ~ADDR_W'(3);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_addr;        // address the next written word will take
    logic [ADDR_W-2:0] r_cnt;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_range_ok;
    logic              w_accept;
    logic              w_hs;
    logic              w_start;

    instr_pack u_pack (
        .i_fmt      (i_in_fmt),
        .i_funct3   (i_in_funct3),
        .i_funct7_5 (i_in_funct7_5),
        .i_rd       (i_in_rd),
        .i_rs1      (i_in_rs1),
        .i_rs2      (i_in_rs2),
        .i_imm      (i_in_imm),
        .o_word     (w_word),
        .o_range_ok (w_range_ok)
    );

    assign w_accept = i_in_valid && o_in_ready;
    assign w_hs     = r_out_valid && i_out_ready;
    assign w_start  = (r_state == ST_IDLE) && i_start;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: the last bundle (written or rejected) starts the drain
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start)                      w_next_state = ST_RUN;
            ST_RUN:   if (w_accept && i_in_last)        w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_out_valid || i_out_ready)  w_next_state = ST_DONE;
            ST_DONE:                                    w_next_state = ST_IDLE;
            default:                                    w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; a new bundle fits whenever the output slot is empty or emptying
    always_comb begin
        o_in_ready = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            ST_RUN:  o_in_ready = !r_out_valid || i_out_ready;
            ST_DONE: o_done     = 1'b1;
            default: ;
        endcase
    end

    // Output slot: load on a written bundle, clear once the IMEM handshake completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_addr  <= '0;
        end else if (w_accept && w_range_ok) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_addr  <= r_addr;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Address, word count and sticky error; START re-arms them for a new program
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= L_BASE;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (w_start) begin
            r_addr <= L_BASE;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_cnt <= r_cnt + (ADDR_W-1)'(1);
            end
            if (w_accept && w_range_ok) begin
                r_addr <= r_addr + ADDR_W'(4);
            end
            if (w_accept && !w_range_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_err       = r_err;
    assign o_instr_cnt = r_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus randomized programs checked against a queue-based reference model.
// Latency: model expects a written bundle on OUT_* the cycle after acceptance.
// Backpressure: OUT_READY is driven directed or randomized to exercise stalls.
module tb_instr_encoder;

    localparam int          AW   = 12;
    localparam logic [AW-1:0] BASE = '0;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic          i_in_valid;
    logic          o_in_ready;
    logic          i_in_last;
    logic [2:0]    i_in_fmt;
    logic [2:0]    i_in_funct3;
    logic          i_in_funct7_5;
    logic [4:0]    i_in_rd;
    logic [4:0]    i_in_rs1;
    logic [4:0]    i_in_rs2;
    logic [31:0]   i_in_imm;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [AW-1:0] o_out_addr;
    logic [31:0]   o_out_data;
    logic          o_err;
    logic          o_done;
    logic [AW-2:0] o_instr_cnt;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_last     (i_in_last),
        .i_in_fmt      (i_in_fmt),
        .i_in_funct3   (i_in_funct3),
        .i_in_funct7_5 (i_in_funct7_5),
        .i_in_rd       (i_in_rd),
        .i_in_rs1      (i_in_rs1),
        .i_in_rs2      (i_in_rs2),
        .i_in_imm      (i_in_imm),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_addr    (o_out_addr),
        .o_out_data    (o_out_data),
        .o_err         (o_err),
        .o_done        (o_done),
        .o_instr_cnt   (o_instr_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: pending IMEM writes, next address, count, sticky error, program phase
    // phase 0 = waiting for START, 1 = taking bundles, 2 = flushing last write, 3 = done pulse
    logic [31:0]   q_word[$];
    logic [AW-1:0] q_addr[$];
    logic [AW-1:0] m_addr;
    logic [AW-2:0] m_cnt;
    logic          m_err;
    int            m_phase;
    int            n_vec;
    int            n_fail;
    bit            rnd_ready;
    logic [31:0]   bnd [13];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Instruction word from the RV32I field layouts, built with shifts and masks
    function automatic logic [31:0] m_word(input logic [2:0] fmt, input logic [2:0] f3,
                                           input logic f75, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] d, a, b, f, s;
        d = 32'(rd); a = 32'(rs1); b = 32'(rs2); f = 32'(f3); s = 32'(f75);
        case (fmt)
            3'd0: return (s << 30) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | 32'h33;
            3'd1: if (f3 == 3'd1 || f3 == 3'd5)
                      return (s << 30) | ((imm & 32'd31) << 20) | (a << 15) | (f << 12) | (d << 7) | 32'h13;
                  else
                      return (imm << 20) | (a << 15) | (f << 12) | (d << 7) | 32'h13;
            3'd2: return (imm << 20) | (a << 15) | (f << 12) | (d << 7) | 32'h03;
            3'd3: return (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
                         | ((imm & 32'd31) << 7) | 32'h23;
            3'd4: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (b << 20)
                         | (a << 15) | (f << 12) | (((imm >> 1) & 32'd15) << 8)
                         | (((imm >> 11) & 32'd1) << 7) | 32'h63;
            3'd5: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                         | (d << 7) | 32'h6F;
            3'd6: return (imm << 20) | (a << 15) | (d << 7) | 32'h67;
            default: return 32'h0;
        endcase
    endfunction

    // Whether a bundle gets written, from the numeric range of the signed immediate
    function automatic bit m_legal(input logic [2:0] fmt, input logic [2:0] f3, input logic [31:0] imm);
        int s;
        bit rng;
        s = $signed(imm);
        case (fmt)
            3'd1:       rng = (f3 == 3'd1 || f3 == 3'd5) ? (s >= 0 && s <= 31) : (s >= -2048 && s <= 2047);
            3'd2, 3'd3,
            3'd6:       rng = (s >= -2048 && s <= 2047);
            3'd4:       rng = (s >= -4096 && s <= 4095) && (imm[0] == 1'b0);
            3'd5:       rng = (s >= -1048576 && s <= 1048575) && (imm[0] == 1'b0);
            default:    rng = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        return (fmt != 3'd7) && rng;
`else
        // range result is ignored when checking is off
        return (fmt != 3'd7) && (rng || 1'b1);
`endif
    endfunction

    task automatic model_reset();
        q_word.delete();
        q_addr.delete();
        m_phase = 0;
        m_err   = 1'b0;
        m_cnt   = '0;
        m_addr  = BASE;
    endtask

    // One clock: check every output against the model, then advance the model across the edge
    task automatic tick(output bit acc);
        bit exp_vld, exp_rdy, hs;
        if (rnd_ready) i_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_vld = (q_word.size() != 0);
        exp_rdy = (m_phase == 1) && (!exp_vld || i_out_ready);
        chk("in_ready",  32'(o_in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(o_out_valid), 32'(exp_vld));
        chk("err",       32'(o_err),       32'(m_err));
        chk("done",      32'(o_done),      32'(m_phase == 3));
        chk("instr_cnt", 32'(o_instr_cnt), 32'(m_cnt));
        if (exp_vld) begin
            chk("out_addr", 32'(o_out_addr), 32'(q_addr[0]));
            chk("out_data", o_out_data, q_word[0]);
        end
        acc = i_in_valid && exp_rdy;
        hs  = exp_vld && i_out_ready;
        if (hs) begin
            void'(q_word.pop_front());
            void'(q_addr.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        case (m_phase)
            0: if (i_start) begin
                   m_phase = 1; m_addr = BASE; m_cnt = '0; m_err = 1'b0;
               end
            1: if (acc) begin
                   if (m_legal(i_in_fmt, i_in_funct3, i_in_imm)) begin
                       q_word.push_back(m_word(i_in_fmt, i_in_funct3, i_in_funct7_5,
                                               i_in_rd, i_in_rs1, i_in_rs2, i_in_imm));
                       q_addr.push_back(m_addr);
                       m_addr = m_addr + AW'(4);
                   end else begin
                       m_err = 1'b1;
                   end
                   if (i_in_last) m_phase = 2;
               end
            2: if (!exp_vld || hs) m_phase = 3;
            default: m_phase = 0;
        endcase
        @(negedge i_clk);
    endtask

    task automatic start_prog();
        bit acc;
        i_start = 1'b1;
        tick(acc);
        i_start = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [2:0] f3, input logic f75,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        bit acc;
        int n;
        i_in_valid = 1'b1; i_in_fmt = fmt; i_in_funct3 = f3; i_in_funct7_5 = f75;
        i_in_rd = rd; i_in_rs1 = rs1; i_in_rs2 = rs2; i_in_imm = imm; i_in_last = last;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            tick(acc);
            n++;
        end
        chk("send_accept_bound", 32'(acc), 32'd1);
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit acc;
        int n;
        n = 0;
        while ((m_phase != 0 || q_word.size() != 0) && n < 200) begin
            tick(acc);
            n++;
        end
        chk("drain_bound", 32'(n < 200), 32'd1);
        tick(acc);
    endtask

    initial begin
        bit acc;
        int len, gap;
        logic [2:0]  r_fmt, r_f3;
        logic        r_f75;
        logic [4:0]  r_rd, r_rs1, r_rs2;
        logic [31:0] r_imm;

        bnd = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31, 32'd32, 32'd4094,
                32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000};
        n_vec = 0; n_fail = 0; rnd_ready = 1'b0;
        i_rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_in_last = 1'b0;
        i_in_fmt = '0; i_in_funct3 = '0; i_in_funct7_5 = 1'b0;
        i_in_rd = '0; i_in_rs1 = '0; i_in_rs2 = '0; i_in_imm = '0; i_out_ready = 1'b1;
        model_reset();

        // Reset values
        repeat (2) @(negedge i_clk);
        chk("rst_in_ready",  32'(o_in_ready),  32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_out_addr",  32'(o_out_addr),  32'd0);
        chk("rst_out_data",  o_out_data,       32'd0);
        chk("rst_err",       32'(o_err),       32'd0);
        chk("rst_done",      32'(o_done),      32'd0);
        chk("rst_instr_cnt", 32'(o_instr_cnt), 32'd0);
        i_rst_n = 1'b1;
        tick(acc);

        // ADDI x1, x0, 5
        start_prog();
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        chk("addi_data", o_out_data, 32'h0050_0093);
        chk("addi_addr", 32'(o_out_addr), 32'd0);
        wait_idle();

        // ADD then SW back-to-back
        start_prog();
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add_data", o_out_data, 32'h0020_81B3);
        chk("add_addr", 32'(o_out_addr), 32'd0);
        send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
        chk("sw_data", o_out_data, 32'h0020_A423);
        chk("sw_addr", 32'(o_out_addr), 32'd4);
        wait_idle();

        // BEQ -4 then JAL 2048 as last; DONE one cycle after the final handshake
        start_prog();
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        chk("beq_data", o_out_data, 32'hFE20_8EE3);
        send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
        chk("jal_data", o_out_data, 32'h0010_00EF);
        tick(acc);
        chk("jal_done", 32'(o_done), 32'd1);
        chk("jal_cnt",  32'(o_instr_cnt), 32'd2);
        wait_idle();

        // Out-of-range ADDI immediate
        start_prog();
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
`ifdef ENC_RANGE_CHECK_EN
        chk("range_err",   32'(o_err),       32'd1);
        chk("range_nowr",  32'(o_out_valid), 32'd0);
`else
        chk("trunc_data",  o_out_data,       32'h8000_0093);
        chk("trunc_err",   32'(o_err),       32'd0);
`endif
        send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
        chk("range_next_addr", 32'(o_out_addr), 32'd0);
`else
        chk("trunc_next_addr", 32'(o_out_addr), 32'd4);
`endif
        wait_idle();
`ifdef ENC_RANGE_CHECK_EN
        chk("range_err_sticky", 32'(o_err), 32'd1);
`endif

        // Stall: OUT_READY low for 3 cycles with a bundle waiting
        start_prog();
        i_out_ready = 1'b0;
        send(3'd2, 3'd2, 1'b0, 5'd7, 5'd3, 5'd0, 32'hFFFF_FFF0, 1'b0);
        i_in_valid = 1'b1; i_in_fmt = 3'd6; i_in_rd = 5'd1; i_in_rs1 = 5'd5; i_in_imm = 32'd12;
        repeat (3) tick(acc);
        chk("stall_in_ready", 32'(o_in_ready), 32'd0);
        chk("stall_data",     o_out_data,      32'hFF01_A383);
        i_out_ready = 1'b1;
        send(3'd6, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd12, 1'b1);
        chk("stall_jalr_data", o_out_data, 32'h00C2_80E7);
        wait_idle();

        // Reset while a write is pending
        start_prog();
        i_out_ready = 1'b0;
        send(3'd1, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd9, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("mid_rst_out_data",  o_out_data,       32'd0);
        chk("mid_rst_out_addr",  32'(o_out_addr),  32'd0);
        chk("mid_rst_in_ready",  32'(o_in_ready),  32'd0);
        model_reset();
        @(negedge i_clk);
        i_in_valid = 1'b1; i_out_ready = 1'b1;
        tick(acc);
        i_rst_n = 1'b1;
        repeat (3) tick(acc);
        i_in_valid = 1'b0;
        tick(acc);

        // Randomized programs with random OUT_READY and input gaps
        for (int p = 0; p < 40; p++) begin
            rnd_ready = 1'b1;
            start_prog();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                r_fmt = 3'($urandom_range(0, 7));
                r_f3  = 3'($urandom_range(0, 7));
                r_f75 = 1'($urandom_range(0, 1));
                r_rd  = 5'($urandom_range(0, 31));
                r_rs1 = 5'($urandom_range(0, 31));
                r_rs2 = 5'($urandom_range(0, 31));
                case ($urandom_range(0, 3))
                    0:       r_imm = 32'($urandom_range(0, 40));
                    1:       r_imm = $urandom;
                    2:       r_imm = 32'($urandom_range(0, 8192)) - 32'd4096;
                    default: r_imm = bnd[$urandom_range(0, 12)];
                endcase
                if ((r_fmt == 3'd4 || r_fmt == 3'd5) && $urandom_range(0, 1) == 1) r_imm[0] = 1'b0;
                send(r_fmt, r_f3, r_f75, r_rd, r_rs1, r_rs2, r_imm, 1'(k == len - 1));
                gap = $urandom_range(0, 2);
                repeat (gap) tick(acc);
            end
            wait_idle();
        end
        rnd_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
